// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers.
// Optional watchdog abort compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 active,
    output logic [IDX_W-1:0]     owner,
    output logic                 err
);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..16");
    end
    if ((2 ** IDX_W) < NUM_REQ) begin : g_bad_idx_w
        $error("uart_tx_arbiter: IDX_W too narrow for NUM_REQ");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 active_q, active_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;

    logic                 found;
    logic [IDX_W-1:0]     win;
    logic [IDX_W-1:0]     next_ptr;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Rotating search: first pass covers rr_q..top, second pass wraps to 0..rr_q-1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= rr_q)) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
    end

    assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        // NOTE: combinational logic uses blocking assignments; only the flop block uses <=.
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        tx_data_d  = tx_data_q;
        active_d   = active_q;
        tx_start_d = 1'b0;
        gnt_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!tx_busy && found) begin
                    tx_data_d  = req_data[8*win +: 8];
                    owner_d    = win;
                    tx_start_d = 1'b1;
                    active_d   = 1'b1;
                    state_d    = ISSUE;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        gnt_d[i] = (win == IDX_W'(i));
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    rr_d     = next_ptr;
                    state_d  = IDLE;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        done_d[i] = (owner_q == IDX_W'(i));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        // The watchdog overrides a frame end landing on the same edge.
        if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                err_d    = 1'b1;
                active_d = 1'b0;
                done_d   = '0;
                rr_d     = next_ptr;
                state_d  = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            owner_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            active_q   <= active_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign active   = active_q;
    assign owner    = owner_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a uart_tx model and grant/done scoreboards.
// The watchdog step runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        active;
    logic [1:0]  owner;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    exp_t gnt_q[$];
    int   done_q[$];
    logic err_allowed = 1'b0;
    logic stuck = 1'b0;

    // uart_tx model: busy rises one edge after start, 10 bit times of one cycle each.
    logic       m_busy;
    logic [9:0] shreg;
    logic [3:0] bitcnt;
    logic       line;
    logic [9:0] cap = '0;

    uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .active(active),
        .owner(owner), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            bitcnt <= '0;
            shreg  <= '1;
        end else if (!m_busy) begin
            if (tx_start && !stuck) begin
                m_busy <= 1'b1;
                shreg  <= {1'b1, tx_data, 1'b0};
                bitcnt <= '0;
            end
        end else if (bitcnt == 4'd9) begin
            m_busy <= 1'b0;
        end else begin
            bitcnt <= bitcnt + 4'd1;
        end
    end

    assign line    = m_busy ? shreg[bitcnt] : 1'b1;
    assign tx_busy = m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every start and done pulse must match the next expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   d;
        if (m_busy) cap <= {line, cap[9:1]};
        if (rst_n) begin
            if (tx_start) begin
                check("start_while_busy", tx_busy, 0);
                if (gnt_q.size() == 0) begin
                    check("start_unexpected", tx_start, 0);
                end else begin
                    e = gnt_q.pop_front();
                    check("owner", owner, e.idx);
                    check("tx_data", tx_data, e.data);
                    check("gnt_onehot", gnt, 32'd1 << e.idx);
                end
            end else if (gnt != 0) begin
                check("gnt_without_start", gnt, 0);
            end
            if (done != 0) begin
                check("gnt_done_overlap", gnt & done, 0);
                if (done_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    d = done_q.pop_front();
                    check("done_idx", done, 32'd1 << d);
                end
            end
            if (err && !err_allowed) check("err_unexpected", err, 0);
        end
    end

    task automatic expect_frame(input int idx, input logic [7:0] data, input bit with_done);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        gnt_q.push_back(e);
        if (with_done) done_q.push_back(idx);
    endtask

    task automatic wait_gnt(input int budget, output int idx, output int cycles);
        idx    = -1;
        cycles = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (gnt != 0) begin
                cycles = k;
                for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
                break;
            end
        end
        if (idx < 0) check("gnt_wait_timeout", gnt, 1);
    endtask

    task automatic wait_busy(input logic level, input int budget);
        bit hit = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (tx_busy == level) begin
                hit = 1;
                break;
            end
        end
        if (!hit) check("busy_wait_timeout", tx_busy, level);
    endtask

    task automatic wait_inactive(input int budget);
        bit hit = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!active && !tx_busy) begin
                hit = 1;
                break;
            end
        end
        if (!hit) check("inactive_wait_timeout", active, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset(input logic [3:0] req_during);
        @(negedge clk);
        rst_n = 1'b0;
        req   = req_during;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        req   = '0;
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        int idx, cyc;
        int order[5] = '{0, 1, 2, 3, 0};

        // Reset with every requester pending.
        do_reset(4'hF);

        // Single frame from requester 2.
        expect_frame(2, 8'hA5, 1);
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        wait_gnt(10, idx, cyc);
        check("single_idx", idx, 2);
        check("single_latency", cyc, 1);
        req = '0;
        wait_busy(1'b1, 10);
        wait_busy(1'b0, 30);
        check("single_done_early", done, 0);
        check("single_active_hold", active, 1);
        @(negedge clk);
        check("single_done", done, 4'b0100);
        check("single_active_clr", active, 0);
        check("single_owner_hold", owner, 2);
        check("single_line", cap, {1'b1, 8'hA5, 1'b0});

        // Round-robin with all four held and re-raised after each grant.
        do_reset(4'h0);
        req_data = 32'h1312_1110;
        for (int k = 0; k < 5; k++) expect_frame(order[k], 8'h10 + 8'(order[k]), 1);
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(50, idx, cyc);
            check("rr_order", idx, order[k]);
            if (idx >= 0) req[idx] = 1'b0;
            @(negedge clk);
            if (k < 4 && idx >= 0) req[idx] = 1'b1;
        end
        req = '0;
        wait_inactive(50);

        // Move rr_ptr to 2 by serving requester 1 alone.
        expect_frame(1, 8'h21, 1);
        req_data = 32'h0000_2100;
        req = 4'b0010;
        wait_gnt(20, idx, cyc);
        req = '0;
        wait_inactive(50);

        // Simultaneous 1 and 3 with rr_ptr=2: 3 first, then 1.
        expect_frame(3, 8'h43, 1);
        expect_frame(1, 8'h41, 1);
        req_data = 32'h4300_4100;
        req = 4'b1010;
        wait_gnt(20, idx, cyc);
        check("simul_first", idx, 3);
        req[3] = 1'b0;
        wait_gnt(50, idx, cyc);
        check("simul_second", idx, 1);
        req[1] = 1'b0;
        wait_inactive(50);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: serializer never raises busy.
        err_allowed = 1'b1;
        stuck = 1'b1;
        expect_frame(2, 8'h5A, 0);
        req_data = 32'h005A_0000;
        req = 4'b0100;
        wait_gnt(20, idx, cyc);
        req = '0;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (err) begin
                cyc = k;
                break;
            end
        end
        check("timeout_cycles", cyc, 16);
        check("timeout_active", active, 0);
        check("timeout_no_done", done, 0);
        @(negedge clk);
        check("timeout_err_pulse", err, 0);
        err_allowed = 1'b0;
        stuck = 1'b0;
        expect_frame(3, 8'h63, 1);
        expect_frame(0, 8'h60, 1);
        req_data = 32'h6300_0060;
        req = 4'b1001;
        wait_gnt(20, idx, cyc);
        check("timeout_next", idx, 3);
        req[3] = 1'b0;
        wait_gnt(50, idx, cyc);
        check("timeout_after", idx, 0);
        req[0] = 1'b0;
        wait_inactive(50);
`endif

        // Reset in the middle of a frame: no done for it afterwards.
        expect_frame(1, 8'h77, 0);
        req_data = 32'h0000_7700;
        req = 4'b0010;
        wait_gnt(20, idx, cyc);
        req = '0;
        repeat (4) @(negedge clk);
        check("midreset_busy", tx_busy, 1);
        check("midreset_active", active, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset_idle", active, 0);

        check("gnt_queue_empty", gnt_q.size(), 0);
        check("done_queue_empty", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
